// File: rtl/fas_pkg.sv
// fas_pkg: shared constants and types for the FAS FIR front end.
//   FAS_DW / FAS_FIR_TAPS / FAS_FIR_CW : sample width, tap count, coefficient width
//   FIR_COEF      : signed Q1.19 taps. The golden-model generator uses the same table.
//   FIR_OUT_SHIFT : shift from the Q9.27 accumulator down to Q8.8
//   Q88_MAX/MIN   : saturation limits of the Q8.8 output
package fas_pkg;

  localparam int FAS_DW        = 16;
  localparam int FAS_FIR_TAPS  = 32;
  localparam int FAS_FIR_CW    = 20;

  localparam int FIR_OUT_SHIFT  = 19;
  localparam int FIR_ROUND_HALF = 1 << (FIR_OUT_SHIFT - 1);

  localparam int Q88_MAX = 32767;
  localparam int Q88_MIN = -32768;

  typedef logic signed [FAS_DW-1:0] fas_sample_t;

  // Symmetric low-pass taps. The taps sum to about 1.29, so a full-scale DC
  // input drives the output into saturation.
  localparam logic signed [FAS_FIR_CW-1:0] FIR_COEF [0:FAS_FIR_TAPS-1] = '{
    20'sd1024,  20'sd2048,  20'sd3072,  20'sd4601,
    20'sd6144,  20'sd8192,  20'sd10240, 20'sd13313,
    20'sd16384, 20'sd20480, 20'sd24576, 20'sd30720,
    20'sd36864, 20'sd45056, 20'sd53248, 20'sd61440,
    20'sd61440, 20'sd53248, 20'sd45056, 20'sd36864,
    20'sd30720, 20'sd24576, 20'sd20480, 20'sd16384,
    20'sd13313, 20'sd10240, 20'sd8192,  20'sd6144,
    20'sd4601,  20'sd3072,  20'sd2048,  20'sd1024
  };

endpackage

// File: rtl/fas_fir_addtree.sv
// fas_fir_addtree: registered N-input signed adder tree.
//   clk, rst : clock and asynchronous active-high reset
//   terms    : N signed IW-bit operands, packed with term k at [k*IW +: IW]
//   sum      : registered signed sum, OW = IW + log2(N) bits, so it cannot overflow
// The tree is combinational. One register sits at the root.
module fas_fir_addtree #(
  parameter int N  = 32,
  parameter int IW = 36,
  parameter int OW = IW + $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*IW-1:0] terms,
  output logic [OW-1:0]   sum
);

  localparam int LEVELS = $clog2(N);

  // Level 0 holds the sign-extended leaves. Each later level halves the count.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int CNT = N >> l;
    logic signed [OW-1:0] s [CNT];
    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < CNT; k++) begin : g_in
        assign s[k] = OW'($signed(terms[k*IW +: IW]));
      end
    end else begin : g_add
      for (genvar k = 0; k < CNT; k++) begin : g_node
        assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else     sum <= g_lvl[LEVELS].s[0];
  end

endmodule

// File: rtl/fas_fir_stream.sv
// fas_fir_stream: streaming FIR front end of the FAS datapath.
//   clk, rst   : clock and asynchronous active-high reset
//   data_valid : data carries a new sample this cycle
//   data       : input sample, signed Q8.8
//   fir_valid  : fir_d carries a new filtered sample this cycle
//   fir_d      : filtered sample, signed Q8.8. It holds its value while fir_valid=0.
// An output appears 2 cycles after its input sample is accepted. The first
// TAPS-1 samples after reset only fill the delay line and produce no output.
// Build option FAS_FIR_ROUND_EN: round half up before the final shift.
// Without it, the shift truncates toward -inf.
module fas_fir_stream
  import fas_pkg::*;
#(
  parameter int TAPS = FAS_FIR_TAPS,
  parameter int DW   = FAS_DW,
  parameter int CW   = FAS_FIR_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic [DW-1:0] data,
  output logic          fir_valid,
  output logic [DW-1:0] fir_d
);

  localparam int PW   = DW + CW;
  localparam int SW   = PW + $clog2(TAPS);
  localparam int CNTW = $clog2(TAPS);

  // The stored line keeps only TAPS-1 older samples. P1 multiplies the window
  // that will exist after this edge's shift, taken directly from data and the
  // stored line. This saves one cycle of latency.
  logic signed [DW-1:0] x     [TAPS-1];
  logic signed [DW-1:0] win   [TAPS];
  logic signed [PW-1:0] prod_d[TAPS];
  logic [TAPS*PW-1:0]   prod_q;
  logic [CNTW-1:0]      fill_cnt;
  logic                 v_p1;
  logic                 v_sum;
  logic [SW-1:0]        sum_raw;
  logic signed [SW-1:0] sum_adj;
  logic signed [SW-1:0] shifted;
  logic [DW-1:0]        fir_next;

  always_comb begin
    win[0] = $signed(data);
    for (int i = 1; i < TAPS; i++) win[i] = x[i-1];
    for (int i = 0; i < TAPS; i++) prod_d[i] = PW'(win[i]) * PW'(FIR_COEF[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS-1; i++) x[i] <= '0;
      fill_cnt <= '0;
    end else if (data_valid) begin
      x[0] <= $signed(data);
      for (int i = 1; i < TAPS-1; i++) x[i] <= x[i-1];
      if (fill_cnt != CNTW'(TAPS-1)) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // A sample yields an output only when the line was already full before it arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      v_p1   <= 1'b0;
    end else begin
      v_p1 <= data_valid && (fill_cnt == CNTW'(TAPS-1));
      if (data_valid) begin
        for (int i = 0; i < TAPS; i++) prod_q[i*PW +: PW] <= prod_d[i];
      end
    end
  end

  fas_fir_addtree #(
    .N (TAPS),
    .IW(PW),
    .OW(SW)
  ) u_addtree (
    .clk  (clk),
    .rst  (rst),
    .terms(prod_q),
    .sum  (sum_raw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_sum <= 1'b0;
    else     v_sum <= v_p1;
  end

  // Q9.27 accumulator to Q8.8. Saturation is applied after rounding, so a
  // value that rounds past the limit still clamps.
  always_comb begin
`ifdef FAS_FIR_ROUND_EN
    sum_adj = $signed(sum_raw) + SW'(FIR_ROUND_HALF);
`else
    sum_adj = $signed(sum_raw);
`endif
    shifted = sum_adj >>> FIR_OUT_SHIFT;
    if (shifted > SW'(Q88_MAX))      fir_next = 16'h7FFF;
    else if (shifted < SW'(Q88_MIN)) fir_next = 16'h8000;
    else                             fir_next = shifted[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fir_valid <= 1'b0;
      fir_d     <= '0;
    end else begin
      fir_valid <= v_sum;
      if (v_sum) fir_d <= fir_next;
    end
  end

endmodule

// File: tb/tb_fas_fir_stream.sv
// tb_fas_fir_stream: scoreboard bench for fas_fir_stream.
// The stimulus process drives inputs 1 ns after each rising edge. A reference
// model pushes the expected output and its due cycle on every accepted
// sample. The monitor compares the DUT output on each falling edge.
module tb_fas_fir_stream;
  import fas_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic [15:0] data = '0;
  logic        fir_valid;
  logic [15:0] fir_d;

  int     checks    = 0;
  int     failures  = 0;
  int     valid_cnt = 0;
  longint cycle     = 0;
  int     acc_cnt   = 0;
  int     hist[$];
  logic [15:0] last_d = '0;

  typedef struct {
    logic [15:0] val;
    longint      due;
  } exp_t;
  exp_t expq[$];

  fas_fir_stream dut (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .data      (data),
    .fir_valid (fir_valid),
    .fir_d     (fir_d)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cycle);
    end
  endtask

  // Reference output: the mathematical convolution over the last 32 accepted
  // samples, scaled to Q8.8 and then clamped.
  function automatic logic [15:0] refOut();
    longint acc = 0;
    longint q;
    for (int i = 0; i < FAS_FIR_TAPS; i++)
      acc += longint'(hist[hist.size()-1-i]) * longint'(FIR_COEF[i]);
`ifdef FAS_FIR_ROUND_EN
    acc += 64'sd262144;
`endif
    q = acc >>> 19;
    if (q > 32767)       return 16'h7FFF;
    else if (q < -32768) return 16'h8000;
    else                 return 16'(q);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cycle = cycle + 1;
    if (rst) begin
      hist.delete();
      acc_cnt = 0;
    end else if (data_valid) begin
      hist.push_back(int'($signed(data)));
      if (hist.size() > FAS_FIR_TAPS) void'(hist.pop_front());
      if (acc_cnt >= FAS_FIR_TAPS-1) begin
        e.val = refOut();
        e.due = cycle + 2;
        expq.push_back(e);
      end
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checkOutput("valid_in_reset", fir_valid, 0);
      checkOutput("d_in_reset", fir_d, 0);
      last_d = '0;
    end else if (fir_valid) begin
      valid_cnt++;
      if (expq.size() == 0) begin
        checkOutput("unexpected_valid", fir_valid, 0);
      end else begin
        e = expq.pop_front();
        checkOutput("fir_d", fir_d, e.val);
        checkOutput("latency", cycle, e.due);
      end
      last_d = fir_d;
    end else begin
      checkOutput("hold", fir_d, last_d);
    end
  end

  task automatic applyStimulus(input logic v, input logic [15:0] d);
    @(posedge clk);
    #1;
    data_valid = v;
    data       = d;
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    data_valid = 1'b0;
    expq.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    applyStimulus(1'b0, 16'h0000);
    for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_pending", expq.size(), 0);
  endtask

  function automatic logic [15:0] randSample();
    logic [15:0] r;
    r = 16'($urandom);
    if (r[15:14] != 2'b00) r = {{7{r[8]}}, r[8:0]};
    return r;
  endfunction

  initial begin
    doReset(3);
    @(negedge clk);
    checkOutput("reset_valid", fir_valid, 0);
    checkOutput("reset_d", fir_d, 0);

    // Impulse. Tap 0 gives 1024*256 = 0x40000, which is the rounding boundary.
    for (int i = 0; i < 31; i++) applyStimulus(1'b1, 16'h0000);
    applyStimulus(1'b1, 16'h0100);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 16'h0000);

    // DC, then positive and negative full scale
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 16'h0100);
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 16'h7FFF);
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 16'h8000);
    drain();

    // Random data with about 50% valid duty
    doReset(2);
    for (int i = 0; i < 200; i++) begin
      while ($urandom_range(0, 1) == 1) applyStimulus(1'b0, 16'($urandom));
      applyStimulus(1'b1, randSample());
    end
    drain();

    // Reset after 100 samples, then 40 fresh samples
    doReset(2);
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, randSample());
    doReset(2);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, randSample());
    drain();

    // 1024 continuous accepts must give 1024-31 outputs
    doReset(2);
    valid_cnt = 0;
    for (int i = 0; i < 1024; i++) applyStimulus(1'b1, randSample());
    drain();
    checkOutput("valid_count_1024", valid_cnt, 993);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
